// File: rtl/pl_pkg.sv
// Shared pipeline-stage types: stage state encoding, RV32I NOP word, F|D payload layout.
package pl_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pl_state_t;

   // addi x0, x0, 0 -- bubble value for instruction-carrying stages
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } fd_hdr_t;

   localparam int FD_W = $bits(fd_hdr_t);

   function automatic fd_hdr_t fd_nop();
      fd_hdr_t h;
      h.instr    = RV_NOP;
      h.pc       = '0;
      h.pc_plus4 = '0;
      return h;
   endfunction

endpackage

// File: rtl/pl_sat_cnt.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects inc one cycle later.
// Backpressure: none; rst is the only way to clear it.
module pl_sat_cnt
   import pl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/pl_stage_skid.sv
// Generic pipeline stage register with valid/ready on both sides, flush-to-NOP, stall counter.
// Latency: 1 cycle from upstream transfer to m_valid when empty or draining the same cycle.
// Backpressure: SKID_EN=1 absorbs one extra beat so s_ready is registered; SKID_EN=0 has s_ready = !m_valid | m_ready.
module pl_stage_skid
   import pl_pkg::*;
#(
   parameter int               WIDTH    = 96,
   parameter logic [WIDTH-1:0] NOP_DATA = {WIDTH{1'b0}},
   parameter bit               SKID_EN  = 1'b1,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] stall_cnt
);

   logic s_xfer_vld;
   logic m_xfer_vld;
   logic stall_vld;

   assign s_xfer_vld = s_valid & s_ready;
   assign m_xfer_vld = m_valid & m_ready;
   assign stall_vld  = m_valid & ~m_ready;

   generate
      if (SKID_EN) begin : g_skid
         pl_state_t        st;
         logic             out_vld;
         logic             in_rdy;
         logic [WIDTH-1:0] out_dat;
         logic [WIDTH-1:0] skid_dat;

         // flush clears contents exactly like rst; only the stall counter differs
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               st       <= ST_EMPTY;
               out_vld  <= 1'b0;
               in_rdy   <= 1'b1;
               out_dat  <= NOP_DATA;
               skid_dat <= NOP_DATA;
            end else begin
               case (st)
                  ST_EMPTY: begin
                     if (s_valid) begin
                        st      <= ST_FULL;
                        out_vld <= 1'b1;
                        out_dat <= s_data;
                     end
                  end
                  ST_FULL: begin
                     if (s_xfer_vld && m_xfer_vld) begin
                        out_dat <= s_data;
                     end else if (s_xfer_vld) begin
                        st       <= ST_SKID;
                        skid_dat <= s_data;
                        in_rdy   <= 1'b0;
                     end else if (m_xfer_vld) begin
                        st      <= ST_EMPTY;
                        out_vld <= 1'b0;
                        out_dat <= NOP_DATA;
                     end
                  end
                  ST_SKID: begin
                     if (m_xfer_vld) begin
                        st       <= ST_FULL;
                        out_dat  <= skid_dat;
                        skid_dat <= NOP_DATA;
                        in_rdy   <= 1'b1;
                     end
                  end
                  default: begin
                     st       <= ST_EMPTY;
                     out_vld  <= 1'b0;
                     in_rdy   <= 1'b1;
                     out_dat  <= NOP_DATA;
                     skid_dat <= NOP_DATA;
                  end
               endcase
            end
         end

         assign s_ready = in_rdy;
         assign m_valid = out_vld;
         assign m_data  = out_dat;
      end else begin : g_pass
         logic             out_vld;
         logic [WIDTH-1:0] out_dat;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               out_vld <= 1'b0;
               out_dat <= NOP_DATA;
            end else if (s_xfer_vld) begin
               out_vld <= 1'b1;
               out_dat <= s_data;
            end else if (m_xfer_vld) begin
               out_vld <= 1'b0;
               out_dat <= NOP_DATA;
            end
         end

         assign s_ready = ~out_vld | m_ready;
         assign m_valid = out_vld;
         assign m_data  = out_dat;
      end
   endgenerate

   pl_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_vld),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pl_stage_skid.sv
// Bench for pl_stage_skid: three instances (default, 4-bit counter, pass-through with RV NOP) against a queue model.
module tb_pl_stage_skid;
   import pl_pkg::*;

   localparam int W = 96;
   localparam logic [W-1:0] NOP2 = {64'd0, RV_NOP};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   rst_v, fl_v, sv_v, mr_v;
   logic [W-1:0] sd [3];

   logic         mv0, mv1, mv2, sr0, sr1, sr2;
   logic [W-1:0] md0, md1, md2;
   logic [15:0]  sc0, sc2;
   logic [3:0]   sc1;

   int nchk = 0;
   int nerr = 0;

   pl_stage_skid u_dut (
      .clk(clk), .rst(rst_v[0]), .flush(fl_v[0]), .s_valid(sv_v[0]), .s_ready(sr0), .s_data(sd[0]),
      .m_valid(mv0), .m_ready(mr_v[0]), .m_data(md0), .stall_cnt(sc0));

   pl_stage_skid #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst_v[1]), .flush(fl_v[1]), .s_valid(sv_v[1]), .s_ready(sr1), .s_data(sd[1]),
      .m_valid(mv1), .m_ready(mr_v[1]), .m_data(md1), .stall_cnt(sc1));

   pl_stage_skid #(.NOP_DATA(NOP2), .SKID_EN(1'b0)) u_pass (
      .clk(clk), .rst(rst_v[2]), .flush(fl_v[2]), .s_valid(sv_v[2]), .s_ready(sr2), .s_data(sd[2]),
      .m_valid(mv2), .m_ready(mr_v[2]), .m_data(md2), .stall_cnt(sc2));

   // Model: each stage is a FIFO of capacity 2 (skid) or 1 (pass) with a stall tally.
   logic [W-1:0] mq [3][2];
   int           mn [3]      = '{0, 0, 0};
   int           mc [3]      = '{0, 0, 0};
   bit           started [3] = '{1'b0, 1'b0, 1'b0};
   int           cmax [3]    = '{65535, 15, 65535};
   logic [W-1:0] mnop [3]    = '{'0, '0, NOP2};
   bit           sx, mx;

   function automatic logic mdl_srdy(int i);
      if (i == 2) return (mn[i] == 0) || mr_v[i];
      return mn[i] < 2;
   endfunction

   function automatic logic [W-1:0] mdl_dat(int i);
      return (mn[i] != 0) ? mq[i][0] : mnop[i];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         sx = sv_v[i] && mdl_srdy(i);
         mx = (mn[i] != 0) && mr_v[i];
         if ((mn[i] != 0) && !mr_v[i] && (mc[i] < cmax[i])) mc[i]++;
         if (rst_v[i]) begin
            mn[i] = 0;
            mc[i] = 0;
            started[i] = 1'b1;
         end else if (fl_v[i]) begin
            mn[i] = 0;
         end else begin
            if (mx) begin
               mq[i][0] = mq[i][1];
               mn[i]--;
            end
            if (sx) begin
               mq[i][mn[i]] = sd[i];
               mn[i]++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic mv, input logic sr, input logic [W-1:0] md,
                           input logic [15:0] sc);
      chk($sformatf("m_valid[%0d]", i), {95'd0, mv}, {95'd0, (mn[i] != 0)});
      chk($sformatf("s_ready[%0d]", i), {95'd0, sr}, {95'd0, mdl_srdy(i)});
      chk($sformatf("m_data[%0d]", i), md, mdl_dat(i));
      chk($sformatf("stall_cnt[%0d]", i), {80'd0, sc}, W'(mc[i]));
   endtask

   always @(negedge clk) begin
      if (started[0]) cmp_inst(0, mv0, sr0, md0, sc0);
      if (started[1]) cmp_inst(1, mv1, sr1, md1, {12'd0, sc1});
      if (started[2]) cmp_inst(2, mv2, sr2, md2, sc2);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_v = '1; fl_v = '0; sv_v = '0; mr_v = '1;
      sd[0] = '0; sd[1] = '0; sd[2] = '0;

      // reset and single fill/drain
      step(1);
      chk("rst_mvalid", {95'd0, mv0}, 0);
      chk("rst_mdata", md0, 0);
      chk("rst_nop_pass", md2, NOP2);
      step(1);
      rst_v = '0;
      chk("rst_sready", {95'd0, sr0}, 1);
      sv_v[0] = 1'b1; sd[0] = 96'hA;
      step(1);
      sv_v[0] = 1'b0;
      chk("fill_mvalid", {95'd0, mv0}, 1);
      chk("fill_mdata", md0, 96'hA);
      step(1);
      chk("drain_mvalid", {95'd0, mv0}, 0);
      chk("drain_mdata", md0, 0);

      // back-pressure into skid
      mr_v[0] = 1'b0; sv_v[0] = 1'b1; sd[0] = 96'hA1;
      step(1);
      sd[0] = 96'hB2;
      step(1);
      chk("skid_sready", {95'd0, sr0}, 0);
      chk("skid_mdata", md0, 96'hA1);
      sd[0] = 96'hC3;
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("hold_sready", {95'd0, sr0}, 0);
         chk("hold_mdata", md0, 96'hA1);
      end
      mr_v[0] = 1'b1;
      step(1);
      chk("unskid_mdata", md0, 96'hB2);
      chk("unskid_sready", {95'd0, sr0}, 1);
      step(1);
      sv_v[0] = 1'b0;
      chk("third_mdata", md0, 96'hC3);
      step(1);
      chk("bp_empty", {95'd0, mv0}, 0);
      chk("bp_stall", {80'd0, sc0}, 4);

      // streaming throughput
      rst_v[0] = 1'b1;
      step(1);
      rst_v[0] = 1'b0; sv_v[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         sd[0] = W'(256 + k);
         step(1);
         chk("stream_sready", {95'd0, sr0}, 1);
         chk("stream_mdata", md0, W'(256 + k));
      end
      sv_v[0] = 1'b0;
      step(1);
      chk("stream_stall", {80'd0, sc0}, 0);
      chk("stream_empty", {95'd0, mv0}, 0);

      // flush while in skid, with a payload offered the same cycle
      mr_v[0] = 1'b0; sv_v[0] = 1'b1; sd[0] = 96'hA1;
      step(1);
      sd[0] = 96'hB2;
      step(1);
      chk("pre_flush_sready", {95'd0, sr0}, 0);
      fl_v[0] = 1'b1; sd[0] = 96'hC3; mr_v[0] = 1'b1;
      step(1);
      fl_v[0] = 1'b0; sv_v[0] = 1'b0;
      chk("flush_mvalid", {95'd0, mv0}, 0);
      chk("flush_mdata", md0, 0);
      chk("flush_sready", {95'd0, sr0}, 1);
      chk("flush_stall", {80'd0, sc0}, 1);
      step(1);
      chk("flush_discard", {95'd0, mv0}, 0);

      // counter saturation on the 4-bit instance
      sv_v[1] = 1'b1; sd[1] = 96'h55; mr_v[1] = 1'b0;
      step(1);
      sv_v[1] = 1'b0;
      step(20);
      chk("sat_cnt", {92'd0, sc1}, 15);
      chk("sat_hold_data", md1, 96'h55);
      rst_v[1] = 1'b1; fl_v[1] = 1'b1;
      step(1);
      rst_v[1] = 1'b0; fl_v[1] = 1'b0; mr_v[1] = 1'b1;
      chk("sat_rst_cnt", {92'd0, sc1}, 0);
      chk("sat_rst_mvalid", {95'd0, mv1}, 0);

      // pass-through instance: combinational ready
      sv_v[2] = 1'b1; sd[2] = 96'hDEAD;
      step(1);
      sd[2] = 96'hBEEF;
      #1;
      chk("pass_sready_comb", {95'd0, sr2}, 1);
      step(1);
      chk("pass_reload", md2, 96'hBEEF);
      sv_v[2] = 1'b0; mr_v[2] = 1'b0;
      #1;
      chk("pass_sready_low", {95'd0, sr2}, 0);
      step(1);
      chk("pass_hold", md2, 96'hBEEF);
      chk("pass_hold_mvalid", {95'd0, mv2}, 1);
      mr_v[2] = 1'b1;
      step(1);
      chk("pass_drain_nop", md2, NOP2);
      chk("pass_drain_mvalid", {95'd0, mv2}, 0);

      step(2);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
